// File: rtl/mdr_mem_port_pkg.sv
// mdr_mem_port_pkg: shared widths, timeout default and FSM state encoding
package mdr_mem_port_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_TIMEOUT = 15;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mdr_mem_port_timer.sv
// mdr_mem_port_timer: wait-cycle counter for a memory access, expired at TIMEOUT-1
module mdr_mem_port_timer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          restart_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          expired_o
);
    logic [CW-1:0] count_q, count_d;
    always_comb count_d = restart_i ? '0 : inc_i ? count_q + CW'(1) : count_q;
    always_ff @(posedge clk) count_q <= clr ? '0 : count_d;
    assign count_o   = count_q;
    assign expired_o = count_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mdr_mem_port.sv
// mdr_mem_port: memory data register with a req/ack RAM port and access timeout
module mdr_mem_port
    import mdr_mem_port_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [ADDR_W-1:0] mar_q,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write_st,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT);
    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mdr_d;
    logic              inc, expired;
    logic [CW-1:0]     count;
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // a store beats a simultaneous MDR load; the dropped load is flagged
                if (write_st) begin
                    state_d = S_WR;
                    addr_d  = mar_q;
                    wdata_d = mdr_q;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = mdr_in;
                end else if (mdr_in && read) begin
                    state_d = S_RD;
                    addr_d  = mar_q;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    busy_d  = 1'b1;
                end else if (mdr_in) begin
                    mdr_d = bus_in;
                end
            end
            S_RD, S_WR: begin
                if (mem_ack) begin
                    mdr_d   = state_q == S_RD ? mem_rdata : mdr_q;
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (expired) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    // count only while waiting in the same access state; any transition restarts it
    assign inc = (state_q == S_RD || state_q == S_WR) && state_d == state_q;
    mdr_mem_port_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timer (
        .clk       (clk),
        .clr       (clr),
        .restart_i (!inc),
        .inc_i     (inc),
        .count_o   (count),
        .expired_o (expired)
    );
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
        end
    end
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    logic unused_count;
    assign unused_count = ^count;
endmodule

// File: tb/tb_mdr_mem_port.sv
// tb_mdr_mem_port: randomized transaction-level check of the MDR memory port
module tb_mdr_mem_port;
    localparam int TO = 15;
    logic        clk = 1'b0, clr = 1'b1, mdr_in = 1'b0, read = 1'b0, write_st = 1'b0, mem_ack = 1'b0;
    logic [31:0] bus_in = '0, mem_rdata = '0;
    logic [8:0]  mar_q = '0;
    logic        mem_req, mem_we, busy, done, err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mdr_q;
    int          total = 0, bad = 0;
    logic [31:0] mdr_exp = '0;

    mdr_mem_port dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .mar_q(mar_q), .mdr_in(mdr_in), .read(read),
        .write_st(write_st), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mdr_q(mdr_q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_load(input logic [31:0] v);
        bus_in = v;
        mdr_in = 1'b1;
        read   = 1'b0;
        tick();
        mdr_in = 1'b0;
        mdr_exp = v;
        chk("bus_mdr", mdr_q, mdr_exp);
        chk("bus_req", mem_req, 0);
        chk("bus_busy", busy, 0);
        chk("bus_done", done, 0);
    endtask

    // one access; ack is sampled at the delay-th edge after the request rises
    task automatic access(input bit wr, input bit conflict, input logic [8:0] addr,
                          input logic [31:0] rdata, input int delay);
        int          req_n, busy_n, done_n, err_n;
        bit          ok;
        logic [31:0] exp_after;
        req_n = 0; busy_n = 0; done_n = 0; err_n = 0;
        ok = delay < TO;
        exp_after = (!wr && ok) ? rdata : mdr_exp;
        mar_q    = addr;
        write_st = wr;
        mdr_in   = !wr || conflict;
        read     = wr ? 1'($urandom) : 1'b1;
        bus_in   = $urandom;
        tick();
        write_st = 1'b0;
        mdr_in   = 1'b0;
        read     = 1'b0;
        mar_q    = 9'($urandom);
        chk("addr", mem_addr, addr);
        chk("we", mem_we, wr);
        if (wr) chk("wdata", mem_wdata, mdr_exp);
        for (int k = 0; k < 20; k++) begin
            req_n  += int'(mem_req);
            busy_n += int'(busy);
            done_n += int'(done);
            err_n  += int'(err);
            if (done) chk("mdr_at_done", mdr_q, exp_after);
            if (mem_req || done) begin
                mdr_in   = 1'($urandom);
                read     = 1'($urandom);
                write_st = 1'($urandom);
                bus_in   = $urandom;
            end else begin
                mdr_in   = 1'b0;
                write_st = 1'b0;
            end
            mem_ack   = k == delay;
            mem_rdata = mem_ack ? rdata : $urandom;
            tick();
            mem_ack = 1'b0;
        end
        mdr_in   = 1'b0;
        write_st = 1'b0;
        chk("req_len", req_n, ok ? delay + 1 : TO);
        chk("busy_len", busy_n, ok ? delay + 1 : TO);
        chk("done_n", done_n, ok ? 1 : 0);
        chk("err_n", err_n, int'(conflict) + (ok ? 0 : 1));
        chk("mdr_end", mdr_q, exp_after);
        chk("req_end", mem_req, 0);
        if (wr) chk("wdata_hold", mem_wdata, mdr_exp);
        mdr_exp = exp_after;
    endtask

    initial begin
        tick();
        tick();
        tick();
        clr = 1'b0;
        chk("rst_mdr", mdr_q, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        bus_load(32'hDEAD_BEEF);
        access(1'b0, 1'b0, 9'h0A5, 32'h1234_5678, 3);
        bus_load(32'hCAFE_0001);
        access(1'b1, 1'b0, 9'h010, 32'h0, 1);
        access(1'b0, 1'b0, 9'h1FF, 32'h5555_AAAA, TO + 2);
        access(1'b0, 1'b0, 9'h000, 32'h0BAD_F00D, 0);
        access(1'b1, 1'b1, 9'h0F0, 32'h0, 2);
        access(1'b0, 1'b0, 9'h001, 32'h7777_0000, TO - 1);
        mar_q  = 9'h033;
        mdr_in = 1'b1;
        read   = 1'b1;
        tick();
        mdr_in = 1'b0;
        read   = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mdr_exp = '0;
        chk("clr_req", mem_req, 0);
        chk("clr_busy", busy, 0);
        chk("clr_mdr", mdr_q, mdr_exp);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 1'b0;
        chk("late_done", done, 0);
        chk("late_err", err, 0);
        chk("late_mdr", mdr_q, mdr_exp);
        tick();
        chk("late_done2", done, 0);
        chk("late_err2", err, 0);
        for (int i = 0; i < 40; i++) begin
            bit wr;
            wr = 1'($urandom);
            if ($urandom_range(0, 3) == 0) bus_load($urandom);
            access(wr, wr && ($urandom_range(0, 2) == 0), 9'($urandom), $urandom,
                   $urandom_range(0, 4) == 0 ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 6));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
